// File: rtl/viterbi_decoder.sv
// rtl/viterbi_decoder.sv - hard-decision K=3 rate-1/2 (7,5) Viterbi decoder, optional VITDEC_ERRCNT_EN error counter
module viterbi_decoder #(
    parameter int TB_DEPTH = 15,
    parameter int PM_W     = 5
) (
    input  logic        Clock,
    input  logic        reset,
    input  logic        in,
    output logic        out,
    output logic        out_valid
`ifdef VITDEC_ERRCNT_EN
    ,
    output logic [15:0] err_cnt
`endif
);

    localparam int CNT_W = $clog2(TB_DEPTH);
    localparam logic [PM_W-1:0] PM_MAX  = '1;
    localparam logic [PM_W-1:0] PM_INIT = (PM_W > 2) ? PM_W'(4) : PM_MAX;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB_DEPTH - 1);

    logic                phase;
    logic                r0;
    logic [CNT_W-1:0]    cnt;
    logic [PM_W-1:0]     pm    [4];
    logic [TB_DEPTH-1:0] sp    [4];
    logic [PM_W-1:0]     pm_nx [4];
    logic [TB_DEPTH-1:0] sp_nx [4];
    logic [PM_W:0]       raw   [4];
    logic [1:0]          bm_ch [4];
    logic [PM_W:0]       mn;
    logic [PM_W:0]       diff;
    logic [1:0]          best;

    // Hamming distance between the received pair and the branch label of pred -> {u,pred[1]}
    function automatic logic [1:0] branch_metric(input logic [1:0] pred, input logic u,
                                                 input logic a, input logic b);
        logic g0, g1;
        g0 = u ^ pred[1] ^ pred[0];
        g1 = u ^ pred[0];
        return {1'b0, a ^ g0} + {1'b0, b ^ g1};
    endfunction

    always_comb begin
        mn   = '0;
        diff = '0;
        best = 2'd0;
        for (int n = 0; n < 4; n++) begin
            logic [1:0]    nn, p0, p1, b0, b1;
            logic [PM_W:0] c0, c1;
            nn = 2'(n);
            p0 = {nn[0], 1'b0};
            p1 = {nn[0], 1'b1};
            b0 = branch_metric(p0, nn[1], r0, in);
            b1 = branch_metric(p1, nn[1], r0, in);
            c0 = {1'b0, pm[p0]} + (PM_W+1)'(b0);
            c1 = {1'b0, pm[p1]} + (PM_W+1)'(b1);
            if (c1 < c0) begin
                raw[n]   = c1;
                bm_ch[n] = b1;
                sp_nx[n] = {sp[p1][TB_DEPTH-2:0], nn[1]};
            end else begin
                raw[n]   = c0;
                bm_ch[n] = b0;
                sp_nx[n] = {sp[p0][TB_DEPTH-2:0], nn[1]};
            end
        end
        mn = raw[0];
        for (int n = 1; n < 4; n++)
            if (raw[n] < mn) mn = raw[n];
        for (int n = 0; n < 4; n++) begin
            diff     = raw[n] - mn;
            pm_nx[n] = (diff > {1'b0, PM_MAX}) ? PM_MAX : diff[PM_W-1:0];
        end
        for (int n = 1; n < 4; n++)
            if (pm_nx[n] < pm_nx[best]) best = 2'(n);
    end

    always_ff @(posedge Clock) begin
        if (!reset) begin
            phase     <= 1'b0;
            r0        <= 1'b0;
            cnt       <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            pm[0]     <= '0;
            for (int n = 1; n < 4; n++) pm[n] <= PM_INIT;
            for (int n = 0; n < 4; n++) sp[n] <= '0;
        end else begin
            phase <= ~phase;
            if (!phase) begin
                r0 <= in;
            end else begin
                pm  <= pm_nx;
                sp  <= sp_nx;
                out <= sp_nx[best][TB_DEPTH-1];
                if (cnt == CNT_LAST) out_valid <= 1'b1;
                else                 cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef VITDEC_ERRCNT_EN
    always_ff @(posedge Clock) begin
        if (!reset)
            err_cnt <= '0;
        else if (phase && bm_ch[best] != 2'd0 && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb/tb_viterbi_decoder.sv - scoreboard bench for viterbi_decoder
module tb_viterbi_decoder;

    localparam int TB_DEPTH = 15;

    logic Clock = 1'b0;
    logic reset = 1'b0;
    logic in    = 1'b0;
    logic out, out_valid;
`ifdef VITDEC_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    int   vectors     = 0;
    int   miscompares = 0;
    int   e           = 0;
    logic exp_valid   = 1'b0;
    logic sb[$];

    viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(5)) dut (
        .Clock     (Clock),
        .reset     (reset),
        .in        (in),
        .out       (out),
        .out_valid (out_valid)
`ifdef VITDEC_ERRCNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, e);
        end
    endtask

    // One Clock edge; outputs sampled 1 time unit after the edge
    task automatic clk_edge(input logic b, input logic rst_n);
        logic exp_bit;
        reset = rst_n;
        in    = b;
        @(posedge Clock);
        #1;
        if (!rst_n) begin
            e         = 0;
            exp_valid = 1'b0;
            sb.delete();
            chk("rst_out", out, 1'b0);
            chk("rst_valid", out_valid, 1'b0);
`ifdef VITDEC_ERRCNT_EN
            chk("rst_errcnt", err_cnt, 0);
`endif
        end else begin
            if (e % 2 == 1 && (e - 1) / 2 >= TB_DEPTH - 1) begin
                exp_valid = 1'b1;
                if (sb.size() == 0) begin
                    chk("sb_underflow", sb.size(), 1);
                end else begin
                    exp_bit = sb.pop_front();
                    chk("out", out, exp_bit);
                end
            end
            chk("out_valid", out_valid, exp_valid);
            e++;
        end
    endtask

    // Encode info (LSB first, zeros past bit 63) and drive n symbols; optional flipped G0 and abort edge
    task automatic send_msg(input logic [63:0] info, input int n, input int flip_sym, input int abort_edge);
        logic [1:0] s;
        logic       u, g0, g1;
        s = 2'b00;
        for (int k = 0; k < n; k++) begin
            u  = (k < 64) ? info[k] : 1'b0;
            g0 = u ^ s[1] ^ s[0];
            g1 = u ^ s[0];
            s  = {u, s[1]};
            sb.push_back(u);
            if (e == abort_edge) begin clk_edge(1'b0, 1'b0); return; end
            clk_edge(g0 ^ (k == flip_sym), 1'b1);
            if (e == abort_edge) begin clk_edge(1'b0, 1'b0); return; end
            clk_edge(g1, 1'b1);
        end
    endtask

    initial begin
        for (int i = 0; i < 5; i++) clk_edge(1'($urandom_range(1)), 1'b0);

        send_msg(64'h0, TB_DEPTH + 5, -1, -1);

        clk_edge(1'b0, 1'b0);
        send_msg(64'hD, TB_DEPTH + 8, -1, -1);
`ifdef VITDEC_ERRCNT_EN
        chk("errcnt_clean", err_cnt, 0);
`endif

        clk_edge(1'b0, 1'b0);
        send_msg(64'hD, TB_DEPTH + 8, 2, -1);

        clk_edge(1'b0, 1'b0);
        send_msg(64'hD, TB_DEPTH + 8, -1, 11);
        send_msg(64'hD, TB_DEPTH + 8, -1, -1);

        clk_edge(1'b0, 1'b0);
        send_msg({$urandom, $urandom}, TB_DEPTH + 30, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
